// File: rtl/pigasus_hit_pkg.sv
// rtl/pigasus_hit_pkg.sv - shared hit entry type and drop counter constants
package pigasus_hit_pkg;

  localparam int HIT_DWIDTH = 16;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

  // Buffer entries are packed with the lane bit above the data word.
  typedef struct packed {
    logic                  lane;
    logic [HIT_DWIDTH-1:0] data;
  } hit_t;

endpackage

// File: rtl/hit_fifo_2w1r.sv
// rtl/hit_fifo_2w1r.sv - hit buffer with two write slots and one registered read head
module hit_fifo_2w1r #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr0_en,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_en,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
    end
  end

  // Slot 1 is only ever enabled together with slot 0, so it lands one past it.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr] <= wr0_data;
    if (wr1_en) mem[wr_ptr + AW'(1)] <= wr1_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hashtable_hit_merge.sv
// rtl/hashtable_hit_merge.sv - merges two hashtable hit lanes into one stream; HIT_MERGE_DROP_CNT_EN enables drop_cnt
module hashtable_hit_merge
  import pigasus_hit_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          din0,
  input  logic                       din0_valid,
  input  logic [DWIDTH-1:0]          din1,
  input  logic                       din1_valid,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_lane,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int FW = $clog2(DEPTH) + 1;

  logic [FW-1:0]   space;
  logic [1:0]      n_valid;
  logic [1:0]      pushes;
  logic [1:0]      drops;
  logic            slot0_en;
  logic            slot1_en;
  logic [DWIDTH:0] slot0;
  logic [DWIDTH:0] slot1;
  logic [DWIDTH:0] head;
  logic            pop;

  // Space comes from the registered fill only; a pop this cycle frees nothing yet.
  always_comb begin
    space   = FW'(DEPTH) - fill;
    n_valid = {1'b0, din0_valid} + {1'b0, din1_valid};
    if (space >= FW'(2))
      pushes = n_valid;
    else if (space == FW'(1))
      pushes = (n_valid != 2'd0) ? 2'd1 : 2'd0;
    else
      pushes = 2'd0;
    drops    = n_valid - pushes;
    slot0_en = (pushes != 2'd0);
    slot1_en = (pushes == 2'd2);
    slot0    = din0_valid ? {1'b0, din0} : {1'b1, din1};
    slot1    = {1'b1, din1};
  end

  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign out_lane  = head[DWIDTH];
  assign out_data  = head[DWIDTH-1:0];

  hit_fifo_2w1r #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (slot0_en),
    .wr0_data (slot0),
    .wr1_en   (slot1_en),
    .wr1_data (slot1),
    .rd_en    (pop),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      fill <= fill + FW'(pushes) - FW'(pop);
      if (drops != 2'd0) overflow <= 1'b1;
    end
  end

`ifdef HIT_MERGE_DROP_CNT_EN
  logic [DROP_CNT_W:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W + 1)'(drops);

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (drop_sum[DROP_CNT_W])
      drop_cnt <= DROP_CNT_MAX;
    else
      drop_cnt <= drop_sum[DROP_CNT_W-1:0];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_hashtable_hit_merge.sv
// tb/tb_hashtable_hit_merge.sv - directed and random checks of hashtable_hit_merge against a queue model
module tb_hashtable_hit_merge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din0 = '0;
  logic        din0_valid = 1'b0;
  logic [15:0] din1 = '0;
  logic        din1_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_lane;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] drop_cnt;

  typedef struct {
    bit          lane;
    logic [15:0] data;
  } ent_t;

  ent_t   q[$];
  bit     m_ovf;
  longint m_drops;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  hashtable_hit_merge #(.DWIDTH(16), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .din0       (din0),
    .din0_valid (din0_valid),
    .din1       (din1),
    .din1_valid (din1_valid),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill       (fill),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop_cnt();
`ifdef HIT_MERGE_DROP_CNT_EN
    return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".fill"}, 32'(fill), 32'(q.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drop_cnt()));
    if (q.size() != 0) begin
      chk({tag, ".data"}, 32'(out_data), 32'(q[0].data));
      chk({tag, ".lane"}, 32'(out_lane), 32'(q[0].lane));
    end
  endtask

  // One clock: drive at negedge, advance the model, check 1 time unit after the edge.
  task automatic step(input string tag, input bit r, input bit v0, input logic [15:0] x0,
                      input bit v1, input logic [15:0] x1, input bit rdy);
    ent_t cand[$];
    int   space;
    int   n;
    @(negedge clk);
    rst = r; din0_valid = v0; din0 = x0; din1_valid = v1; din1 = x1; out_ready = rdy;
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_drops = 0;
    end else begin
      space = 16 - q.size();
      if (v0) cand.push_back('{lane: 1'b0, data: x0});
      if (v1) cand.push_back('{lane: 1'b1, data: x1});
      n = cand.size() < space ? cand.size() : space;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      for (int i = 0; i < n; i++) q.push_back(cand[i]);
      if (cand.size() > n) begin
        m_ovf = 1;
        m_drops += cand.size() - n;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rnd_step(input string tag, input int hit_pct, input int rdy_pct);
    step(tag, 0, $urandom_range(99) < hit_pct, 16'($urandom),
         $urandom_range(99) < hit_pct, 16'($urandom), $urandom_range(99) < rdy_pct);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 0, 0, 16'h0, 0, 16'h0, rdy);
  endtask

  task automatic reset_dut();
    step("rst", 1, 0, 16'h0, 0, 16'h0, 0);
    idle("post_rst", 0);
  endtask

  initial begin
    m_ovf = 0;
    m_drops = 0;

    reset_dut();
    chk("reset.valid", 32'(out_valid), 32'h0);
    chk("reset.fill", 32'(fill), 32'h0);
    chk("reset.overflow", 32'(overflow), 32'h0);
    chk("reset.drop_cnt", 32'(drop_cnt), 32'h0);

    // Dual hit into empty buffer drains in lane order
    step("dual", 0, 1, 16'h0012, 1, 16'h0034, 1);
    chk("dual.first_data", 32'(out_data), 32'h0012);
    chk("dual.first_lane", 32'(out_lane), 32'h0);
    idle("dual_d1", 1);
    chk("dual.second_data", 32'(out_data), 32'h0034);
    chk("dual.second_lane", 32'(out_lane), 32'h1);
    idle("dual_d2", 1);
    chk("dual.empty", 32'(out_valid), 32'h0);

    // Fill to DEPTH with no consumer, then one more dual hit is dropped whole
    for (int i = 0; i < 8; i++) step("fillup", 0, 1, 16'($urandom), 1, 16'($urandom), 0);
    chk("full.fill", 32'(fill), 32'd16);
    chk("full.overflow", 32'(overflow), 32'h0);
    step("full_drop", 0, 1, 16'hAAAA, 1, 16'hBBBB, 0);
    chk("full_drop.overflow", 32'(overflow), 32'h1);
`ifdef HIT_MERGE_DROP_CNT_EN
    chk("full_drop.drop_cnt", 32'(drop_cnt), 32'd2);
`else
    chk("full_drop.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    for (int i = 0; i < 18; i++) idle("drain1", 1);

    // One slot left: lane 0 kept, lane 1 dropped
    reset_dut();
    for (int i = 0; i < 7; i++) step("fill15", 0, 1, 16'($urandom), 1, 16'($urandom), 0);
    step("fill15", 0, 1, 16'h1515, 0, 16'h0, 0);
    chk("fill15.fill", 32'(fill), 32'd15);
    step("one_slot", 0, 1, 16'h0C0C, 1, 16'h0D0D, 0);
    chk("one_slot.fill", 32'(fill), 32'd16);
    chk("one_slot.overflow", 32'(overflow), 32'h1);
`ifdef HIT_MERGE_DROP_CNT_EN
    chk("one_slot.drop_cnt", 32'(drop_cnt), 32'd1);
`else
    chk("one_slot.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    chk("one_slot.tail", 32'(q[15].data), 32'h0C0C);
    for (int i = 0; i < 18; i++) idle("drain2", 1);

    // Push plus pop at fill 3 keeps fill, then wrap the pointers with random traffic
    reset_dut();
    step("f3", 0, 1, 16'h0301, 1, 16'h0302, 0);
    step("f3", 0, 1, 16'h0303, 0, 16'h0, 0);
    step("f3_pushpop", 0, 0, 16'h0, 1, 16'h0304, 1);
    chk("f3_pushpop.fill", 32'(fill), 32'd3);
    chk("f3_pushpop.head", 32'(out_data), 32'h0302);
    for (int i = 0; i < 40; i++) rnd_step("wrap", 50, 60);

    // Reset mid-stream with a concurrent push
    reset_dut();
    for (int i = 0; i < 3; i++) step("f7", 0, 1, 16'($urandom), 1, 16'($urandom), 0);
    step("f7", 0, 1, 16'h0777, 0, 16'h0, 0);
    chk("f7.fill", 32'(fill), 32'd7);
    step("mid_rst", 1, 1, 16'h1111, 1, 16'h2222, 1);
    chk("mid_rst.fill", 32'(fill), 32'd0);
    chk("mid_rst.valid", 32'(out_valid), 32'h0);
    chk("mid_rst.overflow", 32'(overflow), 32'h0);
    chk("mid_rst.drop_cnt", 32'(drop_cnt), 32'h0);

    // Heavy random traffic including overflow episodes
    for (int i = 0; i < 300; i++) rnd_step("rand", 70, 40);
    for (int i = 0; i < 20; i++) idle("drain3", 1);

`ifdef HIT_MERGE_DROP_CNT_EN
    reset_dut();
    for (int i = 0; i < 8; i++) step("sat_fill", 0, 1, 16'h0, 1, 16'h0, 0);
    for (int i = 0; i < 35000; i++) step("sat", 0, 1, 16'h0, 1, 16'h0, 0);
    chk("sat.drop_cnt", 32'(drop_cnt), 32'h0000FFFF);
    step("sat_more", 0, 1, 16'h0, 1, 16'h0, 0);
    chk("sat_more.drop_cnt", 32'(drop_cnt), 32'h0000FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hashtable_hit_merge.md
HASHTABLE_HIT_MERGE -- requirements
Module: hashtable_hit_merge

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16: width of each hit data word.
REQ-002 The block SHALL have parameter DEPTH, default 16: hit buffer entries; a power of two and at least 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports din0/din1, input, DWIDTH bits each: lane 0/lane 1 hit words from the hashtable stage.
REQ-006 The block SHALL have ports din0_valid/din1_valid, input, 1 bit each: lane hit strobes; there is no backpressure toward the hashtable.
REQ-007 The block SHALL have port out_data, output, DWIDTH bits: hit word at the buffer head.
REQ-008 The block SHALL have port out_lane, output, 1 bit: source lane of out_data (0 = din0, 1 = din1).
REQ-009 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): ready/valid handshake to the consumer.
REQ-010 The block SHALL have port fill, output, $clog2(DEPTH)+1 bits: current buffer occupancy.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag meaning at least one hit was dropped.
REQ-012 The block SHALL have port drop_cnt, output, 16 bits: count of dropped hits (see Configuration).

Function
REQ-013 A transfer SHALL occur in any cycle with out_valid && out_ready; the transfer pops the head entry.
REQ-014 The block SHALL accept up to two pushes per cycle: {din0, lane 0} before {din1, lane 1}; when only one lane is valid, that lane takes the first slot.
REQ-015 Space SHALL be computed as DEPTH - fill using the registered fill; a same-cycle pop SHALL NOT create push space.
REQ-016 With space >= 2, both valid hits SHALL be written.
REQ-017 With space == 1 and both lanes valid, the block SHALL write lane 0 and drop lane 1.
REQ-018 With space == 0, the block SHALL drop every valid hit.
REQ-019 The next fill SHALL equal fill + pushes - pop, exactly, including a simultaneous push and pop.
REQ-020 out_valid SHALL equal (fill != 0); out_data and out_lane SHALL be the registered head entry and SHALL hold stable while out_valid && !out_ready.
REQ-021 Latency SHALL be one cycle: a hit pushed into an empty buffer in cycle N gives out_valid = 1 in cycle N+1.
REQ-022 The read and write pointers SHALL wrap modulo DEPTH with no bubble.
REQ-023 overflow SHALL set in the cycle after any drop and SHALL stay set until rst.
REQ-024 Output order SHALL be strictly FIFO across both lanes.

Reset
REQ-025 When rst = 1 at a clock edge, the block SHALL clear both pointers, fill, overflow and drop_cnt, and SHALL drive out_valid = 0 on the next cycle.
REQ-026 Reset SHALL take priority over a push or pop in the same cycle; entries in flight at reset SHALL be discarded.
REQ-027 Buffer storage SHALL NOT require reset; out_data SHALL NOT be relied on while out_valid = 0.

Configuration
REQ-028 With macro HIT_MERGE_DROP_CNT_EN defined, drop_cnt SHALL add 0, 1 or 2 dropped hits per cycle and SHALL saturate at 16'hFFFF.
REQ-029 Without HIT_MERGE_DROP_CNT_EN, drop_cnt SHALL be constant 0, no counter logic SHALL be present, and overflow SHALL be unaffected.

Structure
REQ-030 Package pigasus_hit_pkg SHALL hold: typedef hit_t {lane, data}, constant DROP_CNT_W = 16, and constant DROP_CNT_MAX.
REQ-031 Storage SHALL be a single sub-module, hit_fifo_2w1r: 2-write, 1-read, registered head output.
REQ-032 The top level SHALL contain only the space and drop arbitration, the counters and the flags.

Verification
REQ-033 Empty buffer, din0 = 16'h0012 and din1 = 16'h0034 both valid for one cycle, out_ready = 1 -> next cycle out 0x0012/lane 0, then 0x0034/lane 1, then out_valid = 0.
REQ-034 out_ready = 0, 8 cycles of dual hits into DEPTH = 16 -> fill = 16, overflow = 0; one more dual hit -> both dropped, overflow = 1, drop_cnt = 2 (macro on) or 0 (macro off).
REQ-035 fill = 15, dual hit with no pop -> lane 0 stored, lane 1 dropped, fill = 16, drop_cnt = 1.
REQ-036 fill = 3, single din1 hit plus pop in the same cycle -> fill stays 3, FIFO order preserved; run 40 cycles of traffic so pointers wrap -> exact ordering is checked against a scoreboard.
REQ-037 rst asserted for one cycle mid-stream with fill = 7 and a simultaneous push -> fill = 0, out_valid = 0, overflow = 0, drop_cnt = 0 the next cycle.
REQ-038 Macro on, force 70000 drops -> drop_cnt saturates at 16'hFFFF and does not wrap.
